// File: rtl/user_input_capture_if.sv
// user_input_capture_if: control, raw key and captured-sequence signals of the player input front end.
interface user_input_capture_if #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 5
);
  logic                   clear;
  logic                   enable;
  logic [3:0]             key;
  logic [CNT_W-1:0]       seq_len;
  logic [2*MAX_LEN-1:0]   user_seq;
  logic [CNT_W-1:0]       count;
  logic                   press_valid;
  logic [1:0]             press_code;
  logic                   multi_err;
  logic                   end_user;
  modport master (
    output clear, enable, key, seq_len,
    input  user_seq, count, press_valid, press_code, multi_err, end_user
  );
  modport slave (
    input  clear, enable, key, seq_len,
    output user_seq, count, press_valid, press_code, multi_err, end_user
  );
endinterface

// File: rtl/user_input_capture.sv
// user_input_capture: synchronises and debounces the push-buttons and shifts each accepted press into the user sequence.
module user_input_capture #(
  parameter int MAX_LEN         = 16,
  parameter int CNT_W           = 5,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input logic                 clock_50,
  input logic                 reset,
  user_input_capture_if.slave uic
);
  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_REL} state_e;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);
  logic [3:0]           sync_q, sample_q, pattern_q, pattern_d;
  state_e               state_q, state_d;
  logic [DW-1:0]        db_q, db_d;
  logic                 accept, one_hot, record;
  logic [1:0]           sym;
  logic [CNT_W-1:0]     eff_len, count_q, count_d;
  logic [2*MAX_LEN-1:0] user_seq_q, user_seq_d;
  logic                 press_valid_q, press_valid_d, multi_err_q, multi_err_d, end_user_q, end_user_d;
  logic [1:0]           press_code_q, press_code_d;
  always_ff @(posedge clock_50) begin
    if (reset) begin
      sync_q        <= '0;
      sample_q      <= '0;
      state_q       <= IDLE;
      pattern_q     <= '0;
      db_q          <= '0;
      count_q       <= '0;
      user_seq_q    <= '0;
      press_valid_q <= 1'b0;
      press_code_q  <= '0;
      multi_err_q   <= 1'b0;
      end_user_q    <= 1'b0;
    end else begin
      sync_q        <= ~uic.key;
      sample_q      <= sync_q;
      state_q       <= state_d;
      pattern_q     <= pattern_d;
      db_q          <= db_d;
      count_q       <= count_d;
      user_seq_q    <= user_seq_d;
      press_valid_q <= press_valid_d;
      press_code_q  <= press_code_d;
      multi_err_q   <= multi_err_d;
      end_user_q    <= end_user_d;
    end
  end
  // accept fires once per press, on the last stable cycle of DB_PRESS
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    db_d      = db_q;
    accept    = 1'b0;
    case (state_q)
      IDLE: if (sample_q != '0) begin
        pattern_d = sample_q;
        db_d      = '0;
        state_d   = DB_PRESS;
      end
      DB_PRESS: if (sample_q != pattern_q) state_d = IDLE;
        else if (db_q == DB_LAST) begin
          accept  = 1'b1;
          state_d = HELD;
        end else db_d = db_q + 1'b1;
      HELD: if (sample_q == '0) begin
        db_d    = '0;
        state_d = DB_REL;
      end
      DB_REL: if (sample_q != '0) state_d = HELD;
        else if (db_q == DB_LAST) state_d = IDLE;
        else db_d = db_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    eff_len       = (uic.seq_len > MAX_CNT) ? MAX_CNT : uic.seq_len;
    one_hot       = $onehot(pattern_q);
    sym           = {pattern_q[3] | pattern_q[2], pattern_q[3] | pattern_q[1]};
    record        = accept & one_hot & uic.enable & (count_q < eff_len);
    count_d       = uic.clear ? '0 : count_q + CNT_W'(record);
    user_seq_d    = uic.clear ? '0 : record ? user_seq_q | ({{(2*MAX_LEN-2){1'b0}}, sym} << {count_q, 1'b0}) : user_seq_q;
    press_valid_d = record & ~uic.clear;
    press_code_d  = (record & ~uic.clear) ? sym : press_code_q;
    multi_err_d   = accept & ~one_hot & ~uic.clear;
    end_user_d    = (count_d == eff_len) && (eff_len != '0);
  end
  assign uic.user_seq    = user_seq_q;
  assign uic.count       = count_q;
  assign uic.press_valid = press_valid_q;
  assign uic.press_code  = press_code_q;
  assign uic.multi_err   = multi_err_q;
  assign uic.end_user    = end_user_q;
endmodule

// File: tb/tb_user_input_capture.sv
// tb_user_input_capture: randomized press sequences checked against a symbol-list model of the capture rules.
module tb_user_input_capture;
  localparam int DB  = 4;
  localparam int LAT = 2 + DB + 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  user_input_capture_if #(.MAX_LEN(16), .CNT_W(5)) bus();
  user_input_capture #(.MAX_LEN(16), .CNT_W(5), .DEBOUNCE_CYCLES(DB)) dut (
    .clock_50(clk),
    .reset(rst),
    .uic(bus)
  );
  int tests = 0, fails = 0;
  int cyc = 0, t_fall = 0, pv_n = 0, me_n = 0, lat = -1;
  logic [1:0] pv_code;
  logic eu_at_pv;
  logic [3:0] prev_keys = '0;
  int m_cnt = 0, m_len = 0;
  int m_sym [16];
  bit m_en = 1'b1;
  function automatic int m_eff();
    return (m_len > 16) ? 16 : m_len;
  endfunction
  function automatic bit m_end();
    return (m_cnt == m_eff()) && (m_eff() != 0);
  endfunction
  function automatic logic [31:0] m_seq();
    logic [31:0] r = '0;
    for (int i = 0; i < m_cnt; i++) r = r + (32'(m_sym[i]) << (2 * i));
    return r;
  endfunction
  function automatic bit m_press(logic [3:0] k);
    int s = 0;
    if ($countones(k) != 1) return 1'b0;
    for (int i = 0; i < 4; i++) if (k[i]) s = i;
    if (!m_en || m_cnt >= m_eff()) return 1'b0;
    m_sym[m_cnt] = s;
    m_cnt++;
    return 1'b1;
  endfunction
  task automatic run(input logic [3:0] k, input int n);
    if ((k & ~prev_keys) != '0) t_fall = cyc;
    prev_keys = k;
    bus.key = ~k;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.press_valid) begin
        pv_n++;
        lat = cyc - t_fall;
        pv_code = bus.press_code;
        eu_at_pv = bus.end_user;
      end
      if (bus.multi_err) me_n++;
    end
  endtask
  task automatic clr_mon();
    pv_n = 0;
    me_n = 0;
    lat = -1;
  endtask
  task automatic tap(input logic [3:0] k);
    clr_mon();
    run(k, 10);
    run(4'b0000, 10);
  endtask
  task automatic do_clear();
    bus.clear = 1'b1;
    run(4'b0000, 1);
    bus.clear = 1'b0;
    m_cnt = 0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.clear = 1'b0;
    bus.enable = 1'b1;
    bus.seq_len = 5'd3;
    run(4'b0000, 3);
    tests++; if (bus.user_seq !== '0) begin fails++; $display("FAIL reset_user_seq got=%0h exp=0", bus.user_seq); end
    tests++; if (bus.count !== '0) begin fails++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    tests++; if (bus.press_valid !== 1'b0) begin fails++; $display("FAIL reset_press_valid got=%b exp=0", bus.press_valid); end
    tests++; if (bus.press_code !== 2'd0) begin fails++; $display("FAIL reset_press_code got=%0d exp=0", bus.press_code); end
    tests++; if (bus.multi_err !== 1'b0) begin fails++; $display("FAIL reset_multi_err got=%b exp=0", bus.multi_err); end
    tests++; if (bus.end_user !== 1'b0) begin fails++; $display("FAIL reset_end_user got=%b exp=0", bus.end_user); end
    rst = 1'b0;
    run(4'b0000, 2);
  endtask
  task automatic test_basic();
    int syms [3] = '{2, 0, 3};
    bit exp;
    m_len = 3;
    m_cnt = 0;
    foreach (syms[j]) begin
      exp = m_press(4'(1 << syms[j]));
      tap(4'(1 << syms[j]));
      tests++; if (pv_n !== int'(exp)) begin fails++; $display("FAIL basic_pulses[%0d] got=%0d exp=%0d", j, pv_n, exp); end
      tests++; if (lat !== LAT) begin fails++; $display("FAIL basic_latency[%0d] got=%0d exp=%0d", j, lat, LAT); end
      tests++; if (pv_code !== 2'(syms[j])) begin fails++; $display("FAIL basic_code[%0d] got=%0d exp=%0d", j, pv_code, syms[j]); end
      tests++; if (eu_at_pv !== m_end()) begin fails++; $display("FAIL basic_end_at_pulse[%0d] got=%b exp=%b", j, eu_at_pv, m_end()); end
      tests++; if (bus.count !== 5'(m_cnt)) begin fails++; $display("FAIL basic_count[%0d] got=%0d exp=%0d", j, bus.count, m_cnt); end
    end
    tests++; if (bus.user_seq[5:0] !== 6'b11_00_10) begin fails++; $display("FAIL basic_user_seq got=%b exp=110010", bus.user_seq[5:0]); end
    tests++; if (bus.end_user !== 1'b1) begin fails++; $display("FAIL basic_end_user got=%b exp=1", bus.end_user); end
  endtask
  task automatic test_bounce();
    do_clear();
    m_len = 5;
    bus.seq_len = 5'd5;
    clr_mon();
    run(4'b0010, 2);
    run(4'b0000, 1);
    run(4'b0010, 10);
    run(4'b0000, 2);
    run(4'b0010, 5);
    run(4'b0000, 10);
    void'(m_press(4'b0010));
    tests++; if (pv_n !== 1) begin fails++; $display("FAIL bounce_pulses got=%0d exp=1", pv_n); end
    tests++; if (lat !== LAT) begin fails++; $display("FAIL bounce_latency got=%0d exp=%0d", lat, LAT); end
    tests++; if (pv_code !== 2'd1) begin fails++; $display("FAIL bounce_code got=%0d exp=1", pv_code); end
    tests++; if (bus.user_seq !== m_seq()) begin fails++; $display("FAIL bounce_user_seq got=%0h exp=%0h", bus.user_seq, m_seq()); end
  endtask
  task automatic test_multi();
    void'(m_press(4'b1001));
    tap(4'b1001);
    tests++; if (me_n !== 1) begin fails++; $display("FAIL multi_err_pulses got=%0d exp=1", me_n); end
    tests++; if (pv_n !== 0) begin fails++; $display("FAIL multi_pulses got=%0d exp=0", pv_n); end
    tests++; if (bus.count !== 5'(m_cnt)) begin fails++; $display("FAIL multi_count got=%0d exp=%0d", bus.count, m_cnt); end
  endtask
  task automatic test_saturate();
    logic [3:0] k;
    bit exp;
    bus.seq_len = 5'd2;
    m_len = 2;
    do_clear();
    for (int j = 0; j < 3; j++) begin
      k = 4'(1 << $urandom_range(0, 3));
      exp = m_press(k);
      tap(k);
      tests++; if (pv_n !== int'(exp)) begin fails++; $display("FAIL sat_pulses[%0d] got=%0d exp=%0d", j, pv_n, exp); end
      tests++; if (bus.count !== 5'(m_cnt)) begin fails++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", j, bus.count, m_cnt); end
      tests++; if (bus.end_user !== m_end()) begin fails++; $display("FAIL sat_end_user[%0d] got=%b exp=%b", j, bus.end_user, m_end()); end
      tests++; if (bus.user_seq !== m_seq()) begin fails++; $display("FAIL sat_user_seq[%0d] got=%0h exp=%0h", j, bus.user_seq, m_seq()); end
    end
    do_clear();
    bus.enable = 1'b0;
    m_en = 1'b0;
    void'(m_press(4'b0100));
    tap(4'b0100);
    tests++; if (pv_n !== 0) begin fails++; $display("FAIL disabled_pulses got=%0d exp=0", pv_n); end
    tests++; if (bus.count !== 5'(m_cnt)) begin fails++; $display("FAIL disabled_count got=%0d exp=%0d", bus.count, m_cnt); end
    bus.enable = 1'b1;
    m_en = 1'b1;
  endtask
  task automatic test_clear_accept();
    bus.seq_len = 5'd3;
    m_len = 3;
    do_clear();
    void'(m_press(4'b1000));
    tap(4'b1000);
    tests++; if (bus.count !== 5'(m_cnt)) begin fails++; $display("FAIL clr_pre_count got=%0d exp=%0d", bus.count, m_cnt); end
    clr_mon();
    run(4'b0010, LAT - 1);
    bus.clear = 1'b1;
    run(4'b0010, 1);
    bus.clear = 1'b0;
    m_cnt = 0;
    tests++; if (pv_n !== 0) begin fails++; $display("FAIL clr_pulses got=%0d exp=0", pv_n); end
    tests++; if (bus.count !== 5'(m_cnt)) begin fails++; $display("FAIL clr_count got=%0d exp=%0d", bus.count, m_cnt); end
    tests++; if (bus.user_seq !== m_seq()) begin fails++; $display("FAIL clr_user_seq got=%0h exp=%0h", bus.user_seq, m_seq()); end
    run(4'b0010, 8);
    run(4'b0000, 10);
    tests++; if (pv_n !== 0) begin fails++; $display("FAIL clr_held_pulses got=%0d exp=0", pv_n); end
  endtask
  task automatic test_reset_held();
    do_clear();
    clr_mon();
    run(4'b0100, 10);
    void'(m_press(4'b0100));
    tests++; if (bus.count !== 5'(m_cnt)) begin fails++; $display("FAIL rh_pre_count got=%0d exp=%0d", bus.count, m_cnt); end
    rst = 1'b1;
    run(4'b0100, 3);
    m_cnt = 0;
    tests++; if (bus.count !== 5'(m_cnt)) begin fails++; $display("FAIL rh_count got=%0d exp=%0d", bus.count, m_cnt); end
    tests++; if (bus.user_seq !== m_seq()) begin fails++; $display("FAIL rh_user_seq got=%0h exp=%0h", bus.user_seq, m_seq()); end
    tests++; if (bus.press_code !== 2'd0) begin fails++; $display("FAIL rh_press_code got=%0d exp=0", bus.press_code); end
    rst = 1'b0;
    clr_mon();
    t_fall = cyc;
    run(4'b0100, 10);
    run(4'b0000, 10);
    void'(m_press(4'b0100));
    tests++; if (pv_n !== 1) begin fails++; $display("FAIL rh_pulses got=%0d exp=1", pv_n); end
    tests++; if (lat !== LAT) begin fails++; $display("FAIL rh_latency got=%0d exp=%0d", lat, LAT); end
    tests++; if (bus.user_seq !== m_seq()) begin fails++; $display("FAIL rh_seq got=%0h exp=%0h", bus.user_seq, m_seq()); end
  endtask
  task automatic test_long();
    logic [3:0] k;
    bit exp;
    int extra = 0;
    bus.seq_len = 5'd20;
    m_len = 20;
    do_clear();
    for (int it = 0; it < 48 && extra < 2; it++) begin
      if (m_cnt == 16) extra++;
      k = ($urandom_range(0, 7) == 0) ? 4'b0101 : 4'(1 << $urandom_range(0, 3));
      exp = m_press(k);
      tap(k);
      tests++; if (pv_n !== int'(exp)) begin fails++; $display("FAIL long_pulses[%0d] got=%0d exp=%0d", it, pv_n, exp); end
      tests++; if (me_n !== int'($countones(k) != 1)) begin fails++; $display("FAIL long_multi[%0d] got=%0d exp=%0d", it, me_n, $countones(k) != 1); end
      tests++; if (bus.count !== 5'(m_cnt)) begin fails++; $display("FAIL long_count[%0d] got=%0d exp=%0d", it, bus.count, m_cnt); end
      tests++; if (bus.user_seq !== m_seq()) begin fails++; $display("FAIL long_user_seq[%0d] got=%0h exp=%0h", it, bus.user_seq, m_seq()); end
      tests++; if (bus.end_user !== m_end()) begin fails++; $display("FAIL long_end_user[%0d] got=%b exp=%b", it, bus.end_user, m_end()); end
      if (exp) begin
        tests++; if (lat !== LAT) begin fails++; $display("FAIL long_latency[%0d] got=%0d exp=%0d", it, lat, LAT); end
        tests++; if (pv_code !== 2'(m_sym[m_cnt-1])) begin fails++; $display("FAIL long_code[%0d] got=%0d exp=%0d", it, pv_code, m_sym[m_cnt-1]); end
      end
    end
    tests++; if (bus.count !== 5'd16) begin fails++; $display("FAIL long_final_count got=%0d exp=16", bus.count); end
    tests++; if (bus.end_user !== 1'b1) begin fails++; $display("FAIL long_final_end_user got=%b exp=1", bus.end_user); end
  endtask
  initial begin
    bus.key = 4'hF;
    bus.clear = 1'b0;
    bus.enable = 1'b1;
    bus.seq_len = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_bounce();
    test_multi();
    test_saturate();
    test_clear_accept();
    test_reset_held();
    test_long();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
